regfile_sb: RTL
===============

REGFILE_SB -- requirements
Module: regfile_sb

Interface
REQ-001 Parameter WIDTH, default 16: register data width in bits.
REQ-002 Parameter AW, default 3: register address width; register count NREGS = 2**AW.
REQ-003 clk  input  1  sole clock; all state updates on posedge clk.
REQ-004 reset  input  1  synchronous, active-high reset, sampled on posedge clk.
REQ-005 data_in  input  WIDTH  write data.
REQ-006 writenum  input  AW  write address.
REQ-007 write  input  1  write enable.
REQ-008 reserve  input  1  request to mark register reservenum busy (pending producer).
REQ-009 reservenum  input  AW  register to reserve.
REQ-010 readnum_a  input  AW  read port A address.
REQ-011 readnum_b  input  AW  read port B address.
REQ-012 data_out_a  output  WIDTH  read port A data.
REQ-013 data_out_b  output  WIDTH  read port B data.
REQ-014 ready_a  output  1  port A data valid (register not pending).
REQ-015 ready_b  output  1  port B data valid.
REQ-016 reserve_ack  output  1  reserve accepted this cycle.
REQ-017 busy  output  NREGS  per-register pending flags, bit i = register i.
REQ-018 busy_cnt  output  AW+1  number of set busy bits, range 0..NREGS.

Function
REQ-019 Storage SHALL be NREGS registers of WIDTH bits; each register's write enable SHALL be the one-hot decode of writenum gated by write.
REQ-020 Write: on posedge clk with write=1, reg[writenum] SHALL take data_in and busy[writenum] SHALL clear, unless re-reserved in the same cycle (REQ-023).
REQ-021 A write to a non-busy register SHALL be legal, SHALL update data, and SHALL leave busy unchanged.
REQ-022 reserve_ack SHALL be combinational: reserve AND (NOT busy[reservenum] OR (write AND writenum==reservenum)).
REQ-023 On posedge clk with reserve_ack=1, busy[reservenum] SHALL be 1 next cycle; a reserve accepted in the same cycle as a write to that register takes priority (data written, busy stays/sets 1).
REQ-024 A reserve with reserve_ack=0 SHALL have no effect; the requester retries (no queuing).
REQ-025 Reads SHALL be combinational: data_out_x = reg[readnum_x], ready_x = NOT busy[readnum_x] (base mode, macro undefined).
REQ-026 Ports A and B SHALL be independent; equal addresses SHALL return identical data and ready.
REQ-027 busy_cnt SHALL be a registered counter updated in the same edge as busy: +1 on a set without a clear, -1 on a clear without a set, unchanged otherwise; it SHALL always equal popcount(busy).
REQ-028 busy_cnt SHALL never exceed NREGS nor wrap below 0.

Reset
REQ-029 reset=1 at posedge clk SHALL clear all registers to 0, busy to 0, busy_cnt to 0; reset overrides write and reserve in the same cycle.
REQ-030 After reset, ready_a=ready_b=1, data_out_a=data_out_b=0; reserve_ack follows REQ-022 combinationally (reset not gated into it).
REQ-031 Reset asserted mid-operation SHALL discard all pending reservations; no write in that cycle takes effect.

Configuration
REQ-032 Macro REGFILE_SB_BYPASS_EN: when defined, if write=1 and writenum==readnum_x, data_out_x SHALL be data_in and ready_x SHALL be 1 in the same cycle (write-through forwarding), per port.
REQ-033 When REGFILE_SB_BYPASS_EN is undefined, read ports SHALL show the pre-edge register value and busy state; written data is visible the cycle after the edge.

Verification
REQ-034 Reset, then write=1 writenum=3 data_in=16'hABCD; next cycle readnum_a=3 -> data_out_a=16'hABCD, ready_a=1, busy=8'h00.
REQ-035 reserve=1 reservenum=5 -> reserve_ack=1; next cycle busy=8'h20, busy_cnt=1, readnum_b=5 gives ready_b=0; repeat reserve 5 -> reserve_ack=0, busy_cnt stays 1.
REQ-036 With busy[5]=1: write 5 = 16'h1234 and reserve 5 same cycle -> reserve_ack=1, next cycle reg5=16'h1234, busy[5]=1, busy_cnt=1.
REQ-037 Reserve all 8 registers on successive cycles -> busy=8'hFF, busy_cnt=8; write all 8 -> busy=8'h00, busy_cnt=0, no wrap.
REQ-038 busy=8'h0C, busy_cnt=2, reset=1 with write=1 writenum=2 -> next cycle busy=0, busy_cnt=0, reg2=0.
REQ-039 Bypass: write=1 writenum=7 data_in=16'h00FF, readnum_a=7 same cycle -> with REGFILE_SB_BYPASS_EN data_out_a=16'h00FF ready_a=1; without, old reg7 value and pre-edge ready.

Source files
------------

// File: rtl/regfile_sb.sv
// rtl/regfile_sb.sv - scoreboarded register file with reserve/busy tracking; optional write-through forwarding under REGFILE_SB_BYPASS_EN
module regfile_sb #(
  parameter int WIDTH = 16,
  parameter int AW    = 3
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [WIDTH-1:0]     data_in,
  input  logic [AW-1:0]        writenum,
  input  logic                 write,
  input  logic                 reserve,
  input  logic [AW-1:0]        reservenum,
  input  logic [AW-1:0]        readnum_a,
  input  logic [AW-1:0]        readnum_b,
  output logic [WIDTH-1:0]     data_out_a,
  output logic [WIDTH-1:0]     data_out_b,
  output logic                 ready_a,
  output logic                 ready_b,
  output logic                 reserve_ack,
  output logic [(2**AW)-1:0]   busy,
  output logic [AW:0]          busy_cnt
);

  localparam int NREGS = 2 ** AW;

  logic [WIDTH-1:0] regs_q [NREGS];
  logic [NREGS-1:0] busy_q, busy_d;
  logic [AW:0]      busy_cnt_q, busy_cnt_d;
  logic [NREGS-1:0] wr_en;
  logic [NREGS-1:0] set_vec;
  logic             set_eff;
  logic             clr_eff;

  // Write-enable decode, reserve acceptance and next busy state.
  // A reserve may take a busy register only when that register is being written this cycle;
  // the reserve then wins over the write's clear.
  always_comb begin
    wr_en       = write ? (NREGS'(1) << writenum) : '0;
    reserve_ack = reserve & (~busy_q[reservenum] | (write & (writenum == reservenum)));
    set_vec     = reserve_ack ? (NREGS'(1) << reservenum) : '0;
    busy_d      = (busy_q & ~wr_en) | set_vec;
  end

  // Counter tracks popcount(busy) incrementally: only net 0->1 and 1->0 transitions move it.
  always_comb begin
    set_eff    = reserve_ack & ~busy_q[reservenum];
    clr_eff    = write & busy_q[writenum] & ~(reserve_ack & (reservenum == writenum));
    busy_cnt_d = busy_cnt_q;
    if (set_eff && !clr_eff) begin
      busy_cnt_d = busy_cnt_q + (AW+1)'(1);
    end else if (clr_eff && !set_eff) begin
      busy_cnt_d = busy_cnt_q - (AW+1)'(1);
    end
  end

  // Storage, busy flags and counter; reset discards pending writes and reservations.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NREGS; i++) begin
        regs_q[i] <= '0;
      end
      busy_q     <= '0;
      busy_cnt_q <= '0;
    end else begin
      for (int i = 0; i < NREGS; i++) begin
        if (wr_en[i]) begin
          regs_q[i] <= data_in;
        end
      end
      busy_q     <= busy_d;
      busy_cnt_q <= busy_cnt_d;
    end
  end

  // Combinational read ports, optionally forwarding same-cycle write data.
  always_comb begin
    data_out_a = regs_q[readnum_a];
    ready_a    = ~busy_q[readnum_a];
    data_out_b = regs_q[readnum_b];
    ready_b    = ~busy_q[readnum_b];
`ifdef REGFILE_SB_BYPASS_EN
    if (write && (writenum == readnum_a)) begin
      data_out_a = data_in;
      ready_a    = 1'b1;
    end
    if (write && (writenum == readnum_b)) begin
      data_out_b = data_in;
      ready_b    = 1'b1;
    end
`endif
  end

  assign busy     = busy_q;
  assign busy_cnt = busy_cnt_q;

endmodule
